metronomo_tempo: RTL and testbench

//   Beat-timing stage directly upstream of the metronomo LED rotator.

---
 rtl/metronomo_tempo_if.sv | 10 +
 rtl/metronomo_tempo.sv | 125 ++++++++++++
 tb/tb_metronomo_tempo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/metronomo_tempo_if.sv
// metronomo_tempo_if: tempo request handshake between a requester and the beat-timing stage
interface metronomo_tempo_if #(
    parameter int BPM_W = 9
);
    logic [BPM_W-1:0] bpm_in;
    logic             bpm_valid;
    logic             bpm_ready;
    modport master (output bpm_in, output bpm_valid, input bpm_ready);
    modport slave  (input bpm_in, input bpm_valid, output bpm_ready);
endinterface

// File: rtl/metronomo_tempo.sv
// metronomo_tempo: BPM to cycle period via serial divider, plus beat/bar tick generation
module metronomo_tempo #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int CNT_W       = 32,
    parameter int BPM_W       = 9,
    parameter int BPM_MIN     = 30,
    parameter int BPM_MAX     = 300,
    parameter int BPM_DEFAULT = 60,
    parameter int BEATS       = 4,
    localparam int IDX_W      = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 rst,
    metronomo_tempo_if.slave     bus,
    input  logic                 run_en,
    output logic                 beat_tick,
    output logic                 bar_tick,
    output logic [IDX_W-1:0]     beat_idx,
    output logic [CNT_W-1:0]     period_out
);
    localparam logic [63:0]       N64       = 64'(CLK_HZ) * 64'd60;
    localparam logic [CNT_W-1:0]  N         = N64[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  P_RST     = CNT_W'(N64 / 64'(BPM_DEFAULT));
    localparam logic [CNT_W-1:0]  D_MIN     = CNT_W'(BPM_MIN);
    localparam logic [CNT_W-1:0]  D_MAX     = CNT_W'(BPM_MAX);
    localparam int                STEP_W    = $clog2(CNT_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CNT_W - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, DIV, LOAD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   div_q, div_d, rem_q, rem_d, quo_q, quo_d, period_q, period_d, cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nx;
    logic               beat_q, beat_d, bar_q, bar_d;
    logic [CNT_W:0]     rem_sh;
    logic [CNT_W-1:0]   rem_sub, bpm_ext;
    logic               ge, wrap;

    // restoring division step: shift in next dividend bit (quotient register holds the unconsumed dividend)
    assign rem_sh  = {rem_q, quo_q[CNT_W-1]};
    assign ge      = rem_sh >= {1'b0, div_q};
    assign rem_sub = rem_sh[CNT_W-1:0] - div_q;
    assign bpm_ext = CNT_W'(bus.bpm_in);
    assign wrap    = cnt_q >= period_q - 1'b1;
    assign idx_nx  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    assign bus.bpm_ready = (state_q == IDLE);
    assign beat_tick     = beat_q;
    assign bar_tick      = bar_q;
    assign beat_idx      = idx_q;
    assign period_out    = period_q;

    // request FSM: accept and clamp tempo, divide one bit per cycle, then load the period
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        step_d   = step_q;
        period_d = period_q;
        case (state_q)
            IDLE: if (bus.bpm_valid) begin
                div_d   = (bpm_ext < D_MIN) ? D_MIN : (bpm_ext > D_MAX) ? D_MAX : bpm_ext;
                rem_d   = '0;
                quo_d   = N;
                step_d  = '0;
                state_d = DIV;
            end
            DIV: begin
                rem_d   = ge ? rem_sub : rem_sh[CNT_W-1:0];
                quo_d   = {quo_q[CNT_W-2:0], ge};
                step_d  = step_q + 1'b1;
                state_d = (step_q == STEP_LAST) ? LOAD : DIV;
            end
            LOAD: begin
                period_d = quo_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // beat counter: compare against the period in force, wrap and advance the bar position
    always_comb begin
        cnt_d  = '0;
        idx_d  = IDX_LAST;
        beat_d = 1'b0;
        bar_d  = 1'b0;
        if (run_en) begin
            cnt_d  = wrap ? '0 : cnt_q + 1'b1;
            idx_d  = wrap ? idx_nx : idx_q;
            beat_d = wrap;
            bar_d  = wrap && (idx_nx == '0);
        end
    end

    // state registers; reset abandons any division so no partial period is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= D_MIN;
            rem_q    <= '0;
            quo_q    <= '0;
            step_q   <= '0;
            period_q <= P_RST;
            cnt_q    <= '0;
            idx_q    <= IDX_LAST;
            beat_q   <= 1'b0;
            bar_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            step_q   <= step_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            beat_q   <= beat_d;
            bar_q    <= bar_d;
        end
    end
endmodule

// File: tb/tb_metronomo_tempo.sv
// tb_metronomo_tempo: directed and random checks of metronomo_tempo against a behavioural model
module tb_metronomo_tempo;
    localparam int CNT_W = 16;
    localparam int BPM_W = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             run_en = 1'b0;
    logic             beat_tick, bar_tick;
    logic [1:0]       beat_idx;
    logic [CNT_W-1:0] period_out;
    int               vectors = 0;
    int               errors = 0;

    // model: period in force, pending divider result, busy cycles left, cycles since last beat, beats since start
    int m_period = 100, m_pending = 0, m_busy = 0, m_phase = 0, m_beats = 0;
    bit m_beat = 1'b0, m_bar = 1'b0;

    metronomo_tempo_if #(.BPM_W(BPM_W)) bus ();

    metronomo_tempo #(
        .CLK_HZ(100), .CNT_W(CNT_W), .BPM_W(BPM_W), .BPM_MIN(30),
        .BPM_MAX(300), .BPM_DEFAULT(60), .BEATS(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .run_en(run_en), .beat_tick(beat_tick),
        .bar_tick(bar_tick), .beat_idx(beat_idx), .period_out(period_out)
    );

    always #5 clk = ~clk;

    function automatic int ref_period(int bpm);
        int b;
        b = (bpm < 30) ? 30 : (bpm > 300) ? 300 : bpm;
        return 6000 / b;
    endfunction

    function automatic int m_idx();
        return (m_beats == 0) ? 3 : (m_beats - 1) % 4;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // one clock: advance the model with the inputs seen at the edge, then compare all outputs
    task automatic tick();
        int old_p;
        old_p = m_period;
        @(posedge clk);
        if (rst) begin
            m_period = 100; m_busy = 0; m_phase = 0; m_beats = 0; m_beat = 0; m_bar = 0;
        end else begin
            if (m_busy == 0 && bus.bpm_valid) begin
                m_pending = ref_period(int'(bus.bpm_in));
                m_busy = CNT_W + 1;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_period = m_pending;
            end
            m_beat = 0;
            m_bar = 0;
            if (!run_en) begin
                m_phase = 0;
                m_beats = 0;
            end else if (m_phase + 1 >= old_p) begin
                m_phase = 0;
                m_beats++;
                m_beat = 1;
                m_bar = (m_idx() == 0);
            end else m_phase++;
        end
        #1;
        chk("beat_tick", beat_tick, m_beat);
        chk("bar_tick", bar_tick, m_bar);
        chk("beat_idx", beat_idx, m_idx());
        chk("period_out", period_out, m_period);
        chk("bpm_ready", bus.bpm_ready, m_busy == 0);
    endtask

    task automatic request(int bpm);
        int n;
        n = 0;
        while (!bus.bpm_ready && n < 100) begin n++; tick(); end
        chk("req_wait_timeout", n < 100, 1);
        bus.bpm_in = BPM_W'(bpm);
        bus.bpm_valid = 1'b1;
        tick();
        bus.bpm_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.bpm_ready && n < 100) begin n++; tick(); end
    endtask

    task automatic wait_beat(int idx);
        int n;
        n = 0;
        while (!(beat_tick && beat_idx == 2'(idx)) && n < 2000) begin n++; tick(); end
        chk("beat_wait_timeout", n < 2000, 1);
    endtask

    initial begin
        int n;
        bus.bpm_in = '0;
        bus.bpm_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_period", period_out, 100);
        chk("rst_idx", beat_idx, 3);
        chk("rst_ready", bus.bpm_ready, 1);
        // default tempo: first beat after 100 cycles, bar accent, then idx 1,2,3,0
        run_en = 1'b1;
        repeat (99) tick();
        chk("first_beat_early", beat_tick, 0);
        tick();
        chk("first_beat", beat_tick, 1);
        chk("first_bar", bar_tick, 1);
        chk("first_idx", beat_idx, 0);
        repeat (400) tick();
        chk("fifth_idx", beat_idx, 0);
        chk("fifth_bar", bar_tick, 1);
        // 120 bpm: ready low 17 cycles, period 50
        request(120);
        wait_ready(n);
        chk("busy_len", n, 17);
        chk("p120", period_out, 50);
        repeat (120) tick();
        request(10);
        wait_ready(n);
        chk("p_clamp_lo", period_out, 200);
        request(400);
        wait_ready(n);
        chk("p_clamp_hi", period_out, 20);
        request(90);
        wait_ready(n);
        chk("p_trunc", period_out, 66);
        // back to period 100, then let 20 take effect when 60 cycles into a beat
        request(60);
        wait_ready(n);
        wait_beat(0);
        repeat (42) tick();
        request(300);
        bus.bpm_in = 9'd30;
        bus.bpm_valid = 1'b1;
        wait_ready(n);
        bus.bpm_valid = 1'b0;
        chk("div_valid_ignored", period_out, 20);
        tick();
        chk("switch_beat", beat_tick, 1);
        repeat (19) tick();
        chk("switch_gap", beat_tick, 0);
        tick();
        chk("switch_next", beat_tick, 1);
        // reset in the middle of a division and of a beat
        request(120);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_period", period_out, 100);
        chk("rst_mid_idx", beat_idx, 3);
        chk("rst_mid_ready", bus.bpm_ready, 1);
        chk("rst_mid_tick", beat_tick, 0);
        repeat (30) tick();
        chk("rst_no_partial", period_out, 100);
        // stop at beat 2 and restart
        wait_beat(2);
        run_en = 1'b0;
        repeat (7) tick();
        chk("stop_idx", beat_idx, 3);
        run_en = 1'b1;
        repeat (99) tick();
        chk("restart_early", beat_tick, 0);
        tick();
        chk("restart_beat", beat_tick, 1);
        chk("restart_idx", beat_idx, 0);
        chk("restart_bar", bar_tick, 1);
        // random requests, run_en drops and occasional resets
        for (int i = 0; i < 150; i++) begin
            bus.bpm_in = BPM_W'($urandom_range(0, 511));
            bus.bpm_valid = ($urandom_range(0, 2) == 0);
            run_en = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 50) == 0);
            repeat ($urandom_range(1, 40)) tick();
        end
        rst = 1'b0;
        bus.bpm_valid = 1'b0;
        repeat (50) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
